latch_bank: RTL
===============

# latch_bank

Parametrised multi-channel latch bank that replaces the project's single-bit D latch. Holds CHANNELS stored words of WIDTH bits each, captured from a shared data bus under per-channel asynchronous gate inputs. Each channel is selectable as level-sensitive (transparent while gated) or edge-capture. Instantiated by the project top; the top maps `ui_in` to data and gates and drives `uo_out` from the selected channel's stored word.

## Interface
Parameters:
- `WIDTH`, 8: bits per stored word.
- `CHANNELS`, 4: number of independent storage channels (1..16).
- `SYNC_STAGES`, 2: flip-flop depth of the per-gate synchroniser (>=2).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `gate`  in  CHANNELS  per-channel gate; asynchronous, synchronised internally.
- `mode`  in  1  0 = level (transparent), 1 = edge capture; synchronous, applies to all channels.
- `d`  in  WIDTH  shared data bus; synchronous to `clk`.
- `clr`  in  1  synchronous clear of all stored words and the capture counter.
- `sel`  in  max(1,$clog2(CHANNELS))  readback channel select.
- `q`  out  WIDTH  registered stored word of channel `sel`.
- `cap_count`  out  8  saturating count of channel writes.
- `q_parity`  out  1  even parity of `q` (present only with LATCH_BANK_PARITY_EN).

## Operation
- Synchroniser: `gate[i]` passes through SYNC_STAGES flops to `gs[i]`; `gp[i]` holds the previous `gs[i]`.
- Write enable per channel: level mode `we[i] = gs[i]`; edge mode `we[i] = gs[i] & ~gp[i]`.
- When `we[i]` is set, `store[i] <= d`. Multiple channels enabled in the same cycle all capture the same `d`.
- `gp` updates every cycle regardless of mode. Switching to edge mode while `gs[i]` is already high does not capture until the next rise.
- `clr` has priority over all writes: the stores and `cap_count` go to 0 that cycle. The synchroniser and `gp` are unaffected.
- `cap_count <= min(255, cap_count + popcount(we))`. Level mode counts every written cycle. The count holds at 255.
- Readback: `q <= (sel < CHANNELS) ? store[sel] : 0`, registered.
- Reset values: all stores 0, synchroniser flops 0, `gp` 0, `q` 0, `cap_count` 0, `q_parity` 0.

## Timing
- `gate` rising before edge 0: `gs` is high after edge SYNC_STAGES−1.
- `store` is written at edge SYNC_STAGES with `d` as sampled at that edge. `q` reflects the write at edge SYNC_STAGES+1 (with `sel` already on that channel).
- `sel` change: `q` updates at the next edge (1-cycle latency).
- Level mode: `gate` falling stops writes SYNC_STAGES cycles later. The last `d` sampled while `gs` is high is held.
- Reset mid-operation: all state clears that edge. A gate held high across reset release is seen as a new rising edge, and edge mode captures SYNC_STAGES cycles after `rst` drops.
- `rst` has priority over `clr`.
- `mode` is sampled the same cycle as `we` is formed; no extra latency.

## Configuration
- `LATCH_BANK_PARITY_EN` defined: `q_parity` port exists and is registered alongside `q` as `^q` computed from the same source. It resets to 0 and has the same latency as `q`.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then idle: `q`=0x00 and `cap_count`=0 on all `sel` values; with parity, `q_parity`=0.
- Edge mode, `d`=0xA5, pulse `gate[2]` for 3 cycles, `sel`=2: `q`=0xA5 at edge SYNC_STAGES+1 after the gate rise, `cap_count`=1. Change `d` to 0x3C while gate is still high: `q` stays 0xA5.
- Level mode, `gate[1]` high for 5 synchronised cycles with `d` incrementing 0x10..0x14: `store[1]`=0x14, `cap_count`=5.
- Simultaneous: edge mode, `gate`=4'b1111 rising together, `d`=0x77: all channels read 0x77, `cap_count`=4. Level mode with all gates held high for 70 cycles: `cap_count` saturates at 255.
- `clr` asserted in the same cycle as a write to channel 0 with `d`=0xFF: `store[0]`=0 and `cap_count`=0. `rst` asserted mid-capture clears everything; a gate held high through reset release captures in edge mode SYNC_STAGES cycles later.
- With LATCH_BANK_PARITY_EN: store 0x07 gives `q_parity`=1, store 0x03 gives 0. `sel` out of range (CHANNELS=3, `sel`=3) gives `q`=0.

Source files
------------

// File: rtl/latch_bank.sv
// latch_bank: multi-channel gated storage bank.
// CHANNELS words of WIDTH bits are captured from a shared data bus. Each
// channel has its own asynchronous gate, which passes through a SYNC_STAGES
// flop synchroniser. A global mode input selects the behaviour:
//   mode = 0 : level mode. The store follows d while the gate is high.
//   mode = 1 : edge mode. The store captures d once, on each gate rise.
// The readback word q and the saturating write counter are registered.
// Optional feature: define LATCH_BANK_PARITY_EN to add the q_parity output.
// q_parity is the even-parity bit of q.
module latch_bank #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] gate,
    input  logic                mode,
    input  logic [WIDTH-1:0]    d,
    input  logic                clr,
    input  logic [SEL_W-1:0]    sel,
    output logic [WIDTH-1:0]    q,
`ifdef LATCH_BANK_PARITY_EN
    output logic                q_parity,
`endif
    output logic [7:0]          cap_count
);

    // Number of channels written this cycle. The 5-bit result holds up to 16.
    function automatic logic [4:0] popcount(input logic [CHANNELS-1:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < CHANNELS; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

`ifdef LATCH_BANK_PARITY_EN
    // Even-parity bit: set when the word has an odd number of ones.
    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction
`endif

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] gs_s;
    logic [CHANNELS-1:0] gp_q;
    logic [CHANNELS-1:0] we_s;
    logic [WIDTH-1:0]    store_q [CHANNELS];
    logic [WIDTH-1:0]    store_d [CHANNELS];
    logic [7:0]          cap_count_q;
    logic [7:0]          cap_count_d;
    logic [8:0]          cnt_sum_s;
    logic [WIDTH-1:0]    rd_word_s;
    logic [WIDTH-1:0]    q_q;

    assign gs_s      = sync_q[SYNC_STAGES-1];
    assign q         = q_q;
    assign cap_count = cap_count_q;

    // Gate synchroniser, plus a copy of its output from the previous cycle.
    // Reset clears both. A gate that is still high when reset is released
    // therefore appears as a new rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            gp_q <= '0;
        end else begin
            sync_q[0] <= gate;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            gp_q <= gs_s;
        end
    end

    // Per-channel write enable. Mode takes effect in the same cycle it is sampled.
    always_comb begin
        if (mode) begin
            we_s = gs_s & ~gp_q;
        end else begin
            we_s = gs_s;
        end
    end

    // Next-state logic for the stores and the counter. clr overrides every write.
    always_comb begin
        cnt_sum_s   = {1'b0, cap_count_q} + {4'd0, popcount(we_s)};
        cap_count_d = cap_count_q;
        for (int i = 0; i < CHANNELS; i++) begin
            store_d[i] = store_q[i];
        end
        if (clr) begin
            for (int i = 0; i < CHANNELS; i++) begin
                store_d[i] = '0;
            end
            cap_count_d = 8'd0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (we_s[i]) begin
                    store_d[i] = d;
                end else begin
                    store_d[i] = store_q[i];
                end
            end
            if (cnt_sum_s > 9'd255) begin
                cap_count_d = 8'd255;
            end else begin
                cap_count_d = cnt_sum_s[7:0];
            end
        end
    end

    // Storage words and write counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                store_q[i] <= '0;
            end
            cap_count_q <= 8'd0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                store_q[i] <= store_d[i];
            end
            cap_count_q <= cap_count_d;
        end
    end

    // Readback mux. The AND-OR form returns zero for any sel value that
    // does not match a channel, so out-of-range selects read as 0.
    always_comb begin
        rd_word_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rd_word_s = rd_word_s | (store_q[i] & {WIDTH{sel == SEL_W'(i)}});
        end
    end

`ifdef LATCH_BANK_PARITY_EN
    logic q_parity_q;
    assign q_parity = q_parity_q;

    // Registered readback word, with its parity taken from the same source.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q        <= '0;
            q_parity_q <= 1'b0;
        end else begin
            q_q        <= rd_word_s;
            q_parity_q <= even_parity(rd_word_s);
        end
    end
`else
    // Registered readback word.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= rd_word_s;
        end
    end
`endif

endmodule
